// File: rtl/ysyx_23060025_ifu_fetch_if.sv
// ----------------------------------------------------------------------------
// ysyx_23060025_ifu_fetch_if
// Fetch-side bus between the instruction fetch unit and the icache.
//   out_paddr      fetch address; held from the request cycle through the
//                  response cycle because the icache reads it combinationally
//   out_psel       one-cycle fetch request
//   in_pready      one-cycle response strobe from the icache
//   in_prdata      instruction word, valid while in_pready is high
//   out_fence_flag one-cycle icache invalidate request
// Modports: master = fetch unit, slave = icache.
// ----------------------------------------------------------------------------
interface ysyx_23060025_ifu_fetch_if #(
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] out_paddr;
   logic                  out_psel;
   logic                  in_pready;
   logic [31:0]           in_prdata;
   logic                  out_fence_flag;

   modport master (
      output out_paddr,
      output out_psel,
      output out_fence_flag,
      input  in_pready,
      input  in_prdata
   );

   modport slave (
      input  out_paddr,
      input  out_psel,
      input  out_fence_flag,
      output in_pready,
      output in_prdata
   );
endinterface

// File: rtl/ysyx_23060025_ifu_fetch.sv
// ----------------------------------------------------------------------------
// ysyx_23060025_ifu_fetch
// Instruction fetch stage sitting in front of the icache. Owns the PC, keeps
// at most one fetch outstanding, buffers one returned instruction toward
// decode, applies execute redirects and sequences fence.i invalidation.
// Ports:
//   clock, reset    single clock; asynchronous active-low reset
//   ic              icache bus (master side), see ysyx_23060025_ifu_fetch_if
//   redirect_valid  execute redirect strobe, target on redirect_pc
//   fence_req       fence.i request, only honoured together with redirect_valid
//   ds_valid/ready  handshake of the one-entry buffer toward decode
//   ds_inst, ds_pc  buffered instruction and its PC
//   perf_fetch_cnt  delivered fetches, perf_wait_cyc cycles waiting on icache
// Build option: define IFU_PERF_CNT_EN to implement the two performance
// counters; otherwise both counter ports read as zero.
// ----------------------------------------------------------------------------
module ysyx_23060025_ifu_fetch #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h3000_0000
) (
   input  logic                          clock,
   input  logic                          reset,
   ysyx_23060025_ifu_fetch_if.master     ic,
   input  logic                          redirect_valid,
   input  logic [ADDR_WIDTH-1:0]         redirect_pc,
   input  logic                          fence_req,
   output logic                          ds_valid,
   input  logic                          ds_ready,
   output logic [31:0]                   ds_inst,
   output logic [ADDR_WIDTH-1:0]         ds_pc,
   output logic [31:0]                   perf_fetch_cnt,
   output logic [31:0]                   perf_wait_cyc
);

   typedef enum logic [2:0] {
      S_BOOT   = 3'd0,
      S_REQ    = 3'd1,
      S_WAIT   = 3'd2,
      S_FENCE0 = 3'd3,
      S_FENCE1 = 3'd4
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(32'd4);

   state_t                state_r;
   state_t                state_nxt_s;
   logic [ADDR_WIDTH-1:0] pc_r;
   logic [ADDR_WIDTH-1:0] pending_pc_r;
   logic                  kill_r;
   logic                  fence_pend_r;
   logic                  ds_valid_r;
   logic [31:0]           ds_inst_r;
   logic [ADDR_WIDTH-1:0] ds_pc_r;
   logic                  psel_s;
   logic                  fence_flag_s;
   logic                  fence_hit_s;
   logic                  deliver_s;
   logic [ADDR_WIDTH-1:0] target_s;
   logic                  unused_ok_s;

   // Redirect targets are forced to word alignment; the low bits are dropped.
   assign target_s    = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
   assign unused_ok_s = &{1'b0, redirect_pc[1:0]};
   assign fence_hit_s = redirect_valid & fence_req;
   // A response is only delivered when neither an earlier nor a same-cycle
   // redirect has made it stale.
   assign deliver_s   = (state_r == S_WAIT) & ic.in_pready & ~kill_r & ~redirect_valid;

   assign ic.out_paddr      = pc_r;
   assign ic.out_psel       = psel_s;
   assign ic.out_fence_flag = fence_flag_s;
   assign ds_valid          = ds_valid_r;
   assign ds_inst           = ds_inst_r;
   assign ds_pc             = ds_pc_r;

   // Next-state and request/invalidate decode.
   always_comb begin
      state_nxt_s  = state_r;
      psel_s       = 1'b0;
      fence_flag_s = 1'b0;
      case (state_r)
         S_BOOT: begin
            state_nxt_s = S_REQ;
         end
         S_REQ: begin
            // Only issue when the buffer has room at the next edge.
            psel_s = ~redirect_valid & (~ds_valid_r | ds_ready);
            if (fence_hit_s) begin
               state_nxt_s = S_FENCE0;
            end else if (psel_s) begin
               state_nxt_s = S_WAIT;
            end else begin
               state_nxt_s = S_REQ;
            end
         end
         S_WAIT: begin
            if (ic.in_pready) begin
               // A fence arriving with the response still gets honoured.
               if (fence_pend_r | fence_hit_s) begin
                  state_nxt_s = S_FENCE0;
               end else begin
                  state_nxt_s = S_REQ;
               end
            end else begin
               state_nxt_s = S_WAIT;
            end
         end
         S_FENCE0: begin
            fence_flag_s = 1'b1;
            state_nxt_s  = S_FENCE1;
         end
         S_FENCE1: begin
            if (fence_pend_r | fence_hit_s) begin
               state_nxt_s = S_FENCE0;
            end else begin
               state_nxt_s = S_REQ;
            end
         end
         default: begin
            state_nxt_s = S_BOOT;
         end
      endcase
   end

   // State, PC, pending redirect and fence bookkeeping.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r      <= S_BOOT;
         pc_r         <= RESET_PC;
         pending_pc_r <= RESET_PC;
         kill_r       <= 1'b0;
         fence_pend_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         case (state_r)
            S_BOOT, S_REQ, S_FENCE0, S_FENCE1: begin
               if (redirect_valid) begin
                  pc_r <= target_s;
               end
            end
            S_WAIT: begin
               if (redirect_valid) begin
                  if (ic.in_pready) begin
                     pc_r   <= target_s;
                     kill_r <= 1'b0;
                  end else begin
                     // paddr must stay put until the response; park the target.
                     pending_pc_r <= target_s;
                     kill_r       <= 1'b1;
                  end
               end else if (ic.in_pready) begin
                  if (kill_r) begin
                     pc_r   <= pending_pc_r;
                     kill_r <= 1'b0;
                  end else begin
                     pc_r <= pc_r + PC_STEP;
                  end
               end
            end
            default: begin
               pc_r <= pc_r;
            end
         endcase
         // A fence during WAIT/FENCE is remembered; FENCE0 consumes it.
         if (fence_hit_s && (state_r == S_WAIT || state_r == S_FENCE0 || state_r == S_FENCE1)) begin
            fence_pend_r <= 1'b1;
         end else if (state_r == S_FENCE0) begin
            fence_pend_r <= 1'b0;
         end
      end
   end

   // One-entry instruction buffer toward decode; redirects flush it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ds_valid_r <= 1'b0;
         ds_inst_r  <= 32'd0;
         ds_pc_r    <= '0;
      end else if (redirect_valid) begin
         ds_valid_r <= 1'b0;
      end else if (deliver_s) begin
         ds_valid_r <= 1'b1;
         ds_inst_r  <= ic.in_prdata;
         ds_pc_r    <= pc_r;
      end else if (ds_valid_r && ds_ready) begin
         ds_valid_r <= 1'b0;
      end
   end

`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_cnt_r;
   logic [31:0] wait_cyc_r;

   // Delivered-fetch and icache-wait counters, free-running with wrap.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_cnt_r <= 32'd0;
         wait_cyc_r  <= 32'd0;
      end else begin
         if (deliver_s) begin
            fetch_cnt_r <= fetch_cnt_r + 32'd1;
         end
         if (state_r == S_WAIT) begin
            wait_cyc_r <= wait_cyc_r + 32'd1;
         end
      end
   end

   assign perf_fetch_cnt = fetch_cnt_r;
   assign perf_wait_cyc  = wait_cyc_r;
`else
   assign perf_fetch_cnt = 32'd0;
   assign perf_wait_cyc  = 32'd0;
`endif

endmodule
